// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, subop, ALU control and FSM state encodings shared by the core control and datapath
package ctrl_pkg;
  localparam logic [2:0] OP_ADD = 3'b000, OP_ADDI = 3'b001, OP_SUB = 3'b010, OP_CMP = 3'b011;
  localparam logic [2:0] OP_LW = 3'b100, OP_SW = 3'b101, OP_BR = 3'b110, OP_SYS = 3'b111;
  localparam logic [2:0] SUB_JR = 3'b000, SUB_JMP = 3'b001, SUB_HALT = 3'b111;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_CMP = 3'b010;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_HALT = 3'd4;
  function automatic logic is_mem(input logic [2:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational state/opcode to datapath control table
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [2:0] state,
  input  logic [2:0] op,
  input  logic [2:0] sub,
  input  logic       BranchFlag,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       PcSrc,
  output logic       ALUSrc,
  output logic [1:0] Jump,
  output logic [2:0] ALUControl,
  output logic [2:0] AccControl,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted
);
  logic exec, mem, done;
  // every control is zero unless the current state and opcode call for it
  always_comb begin
    exec = state == S_EXEC;
    mem = state == S_MEM;
    done = mem && mem_ready;
    pc_en = exec || done;
    RegWrite = (exec && (op == OP_ADD || op == OP_ADDI || op == OP_SUB)) || (done && op == OP_LW);
    MemToReg = done && op == OP_LW;
    PcSrc = exec && op == OP_BR && BranchFlag;
    ALUSrc = exec && op == OP_ADDI;
    Jump = !(exec && op == OP_SYS) ? 2'b00 : sub == SUB_JMP ? 2'b01 : sub == SUB_JR ? 2'b11 : 2'b00;
    ALUControl = !exec ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_CMP ? ALU_CMP : ALU_ADD;
    AccControl = RegWrite ? sub : 3'b000;
    mem_req = mem;
    mem_we = mem && op == OP_SW;
    halted = state == S_HALT;
  end
endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle fetch/decode/exec/mem control FSM with halt and sticky overflow
module core_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] inst,
  input  logic       inst_valid,
  input  logic       BranchFlag,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       PcSrc,
  output logic       ALUSrc,
  output logic [1:0] Jump,
  output logic [2:0] ALUControl,
  output logic [2:0] AccControl,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       ovf_sticky
);
  logic [2:0] state, next, op, sub, dec_state;
  logic sticky, unused_imm;
  assign unused_imm = ^inst[2:0];
  // FETCH decodes to all-zero controls, so presenting it during rst silences every output
  always_comb begin
    dec_state = rst ? S_FETCH : state;
    ovf_sticky = sticky && !rst;
    next = state == S_FETCH ? (inst_valid ? S_DECODE : S_FETCH)
         : state == S_DECODE ? (is_mem(op) ? S_MEM : op == OP_SYS && sub == SUB_HALT ? S_HALT : S_EXEC)
         : state == S_MEM ? (mem_ready ? S_FETCH : S_MEM)
         : state == S_HALT ? S_HALT : S_FETCH;
  end
  // state, latched instruction fields and the overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op <= '0;
      sub <= '0;
      sticky <= 1'b0;
    end else begin
      state <= next;
      if (state == S_FETCH && inst_valid) begin
        op <= inst[8:6];
        sub <= inst[5:3];
      end
      if (state == S_EXEC && RegWrite && overflow) sticky <= 1'b1;
    end
  end
  ctrl_decode u_dec (
    .state(dec_state),
    .op(op),
    .sub(sub),
    .BranchFlag(BranchFlag),
    .mem_ready(mem_ready),
    .pc_en(pc_en),
    .RegWrite(RegWrite),
    .MemToReg(MemToReg),
    .PcSrc(PcSrc),
    .ALUSrc(ALUSrc),
    .Jump(Jump),
    .ALUControl(ALUControl),
    .AccControl(AccControl),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .halted(halted)
  );
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed instruction sequences checked against a per-phase behavioural model and literal vectors
module tb_core_ctrl;
  localparam int P_IDLE = 0, P_EXEC = 1, P_MEMW = 2, P_MEMD = 3, P_HALT = 4, P_RST = 5;
  logic clk = 1'b0;
  logic rst, inst_valid, BranchFlag, overflow, mem_ready;
  logic [8:0] inst;
  logic pc_en, RegWrite, MemToReg, PcSrc, ALUSrc, mem_req, mem_we, halted, ovf_sticky;
  logic [1:0] Jump;
  logic [2:0] ALUControl, AccControl;
  logic [16:0] got, exp_v, lit_v;
  logic [8:0] cur;
  logic chk = 1'b0, lit_on = 1'b0, sticky = 1'b0;
  int checks = 0, failures = 0, ph_now = 0;

  core_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .BranchFlag(BranchFlag),
    .overflow(overflow), .mem_ready(mem_ready), .pc_en(pc_en), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .PcSrc(PcSrc), .ALUSrc(ALUSrc), .Jump(Jump), .ALUControl(ALUControl),
    .AccControl(AccControl), .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .ovf_sticky(ovf_sticky)
  );

  assign got = {pc_en, RegWrite, MemToReg, PcSrc, ALUSrc, Jump, ALUControl, AccControl, mem_req, mem_we, halted, ovf_sticky};

  always #5 clk = ~clk;

  // expected output vector for one cycle of an instruction, from the opcode rules alone
  function automatic logic [16:0] model(input int ph, input logic [8:0] i, input logic b, input logic s);
    logic [2:0] op, sub;
    logic [16:0] v;
    logic wr;
    op = i[8:6];
    sub = i[5:3];
    v = '0;
    if (ph == P_EXEC) begin
      wr = (op <= 3'd2);
      v[16] = 1'b1;
      v[15] = wr;
      v[13] = (op == 3'd6) && b;
      v[12] = (op == 3'd1);
      v[11:10] = (op != 3'd7) ? 2'b00 : (sub == 3'd1) ? 2'b01 : (sub == 3'd0) ? 2'b11 : 2'b00;
      v[9:7] = (op == 3'd2) ? 3'd1 : (op == 3'd3) ? 3'd2 : 3'd0;
      v[6:4] = wr ? sub : 3'd0;
    end else if (ph == P_MEMW || ph == P_MEMD) begin
      v[3] = 1'b1;
      v[2] = (op == 3'd5);
      if (ph == P_MEMD) begin
        v[16] = 1'b1;
        v[15] = (op == 3'd4);
        v[14] = (op == 3'd4);
        v[6:4] = (op == 3'd4) ? sub : 3'd0;
      end
    end else if (ph == P_HALT) v[1] = 1'b1;
    v[0] = (ph == P_RST) ? 1'b0 : s;
    return v;
  endfunction

  // the single compare process: model every checked cycle, literal where one is given
  always @(negedge clk) if (chk) begin
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL model ph=%0d t=%0t got=%05h want=%05h", ph_now, $time, got, exp_v);
    end
    if (lit_on) begin
      checks++;
      if (got !== lit_v) begin
        failures++;
        $display("FAIL literal ph=%0d t=%0t got=%05h want=%05h", ph_now, $time, got, lit_v);
      end
    end
  end

  task automatic step(input int ph, input logic [8:0] di, input logic iv, input logic mr, input logic b,
                      input logic o, input logic lon = 1'b0, input logic [16:0] lw = '0);
    inst = di;
    inst_valid = iv;
    mem_ready = mr;
    BranchFlag = b;
    overflow = o;
    ph_now = ph;
    exp_v = model(ph, cur, b, sticky);
    lit_on = lon;
    lit_v = lw;
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(P_RST, 9'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    sticky = 1'b0;
    step(P_IDLE, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'b0);
  endtask

  task automatic run(input logic [8:0] i, input int fw, input int mw, input logic b, input logic o, input logic [16:0] lw);
    logic [2:0] op;
    op = i[8:6];
    cur = i;
    repeat (fw) step(P_IDLE, i, 1'b0, 1'b1, b, o);
    step(P_IDLE, i, 1'b1, 1'b0, b, o);
    step(P_IDLE, ~i, 1'b0, 1'b1, b, o);
    if (i == 9'b111_111_000) begin
      repeat (19) step(P_HALT, ~i, 1'b1, 1'b1, b, o);
      step(P_HALT, ~i, 1'b1, 1'b1, b, o, 1'b1, lw);
    end else if (op == 3'd4 || op == 3'd5) begin
      repeat (mw) step(P_MEMW, ~i, 1'b1, 1'b0, b, o);
      step(P_MEMD, ~i, 1'b1, 1'b1, b, o, 1'b1, lw);
    end else begin
      step(P_EXEC, ~i, 1'b1, 1'b0, b, o, 1'b1, lw);
      if (o && op <= 3'd2) sticky = 1'b1;
    end
  endtask

  // directed program
  initial begin
    rst = 1'b1; inst = '0; inst_valid = 1'b0; BranchFlag = 1'b0; overflow = 1'b0; mem_ready = 1'b0; cur = '0;
    @(posedge clk);
    #1;
    do_reset();
    run(9'b000_001_010, 2, 0, 1'b1, 1'b0, 17'b1_1_0_0_0_00_000_001_0_0_0_0);
    run(9'b011_101_000, 0, 0, 1'b0, 1'b1, 17'b1_0_0_0_0_00_010_000_0_0_0_0);
    run(9'b100_011_001, 1, 3, 1'b1, 1'b1, 17'b1_1_1_0_0_00_000_011_1_0_0_0);
    run(9'b001_010_111, 0, 0, 1'b0, 1'b1, 17'b1_1_0_0_1_00_000_010_0_0_0_0);
    run(9'b010_100_000, 1, 0, 1'b0, 1'b0, 17'b1_1_0_0_0_00_001_100_0_0_0_1);
    run(9'b101_010_000, 0, 1, 1'b0, 1'b0, 17'b1_0_0_0_0_00_000_000_1_1_0_1);
    run(9'b101_110_011, 0, 0, 1'b0, 1'b0, 17'b1_0_0_0_0_00_000_000_1_1_0_1);
    run(9'b110_000_000, 0, 0, 1'b1, 1'b0, 17'b1_0_0_1_0_00_000_000_0_0_0_1);
    run(9'b110_000_000, 0, 0, 1'b0, 1'b0, 17'b1_0_0_0_0_00_000_000_0_0_0_1);
    run(9'b111_001_000, 0, 0, 1'b1, 1'b0, 17'b1_0_0_0_0_01_000_000_0_0_0_1);
    run(9'b111_000_101, 0, 0, 1'b1, 1'b0, 17'b1_0_0_0_0_11_000_000_0_0_0_1);
    run(9'b111_010_000, 0, 0, 1'b1, 1'b1, 17'b1_0_0_0_0_00_000_000_0_0_0_1);
    run(9'b111_111_000, 1, 0, 1'b1, 1'b1, 17'b0_0_0_0_0_00_000_000_0_0_1_1);
    do_reset();
    run(9'b000_110_001, 0, 0, 1'b0, 1'b1, 17'b1_1_0_0_0_00_000_110_0_0_0_0);
    cur = 9'b100_011_001;
    step(P_IDLE, cur, 1'b1, 1'b0, 1'b0, 1'b0);
    step(P_IDLE, cur, 1'b0, 1'b0, 1'b0, 1'b0);
    step(P_MEMW, cur, 1'b0, 1'b0, 1'b0, 1'b0);
    step(P_MEMW, cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'b0_0_0_0_0_00_000_000_1_0_0_1);
    rst = 1'b1;
    step(P_RST, cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'b0);
    rst = 1'b0;
    sticky = 1'b0;
    step(P_IDLE, cur, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'b0);
    step(P_IDLE, cur, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'b0);
    run(9'b000_001_010, 1, 0, 1'b0, 1'b0, 17'b1_1_0_0_0_00_000_001_0_0_0_0);
    chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
